// File: rtl/imem_responder.sv
// imem_responder: preloadable instruction memory behind a valid/ready fetch port.
// A fetch reads the memory when it is accepted. The result passes through a
// LATENCY-stage pipeline and then a QDEPTH-entry response FIFO. When the FIFO
// is empty, the last pipeline stage drives the response port directly.
// Optional feature: define IMEM_ERR_CHECK_EN to flag fetches that are
// misaligned or out of range. Such a fetch returns rsp_err = 1 and rsp_data = 0.
module imem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,  // power of 2, >= 2
    parameter int LATENCY     = 2,    // 1..4
    parameter int QDEPTH      = 4     // power of 2, >= LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data
);

    localparam int MEM_AW = $clog2(DEPTH_WORDS);
    localparam int IDX_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W  = $clog2(QDEPTH + 1);

    localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(QDEPTH - 1);

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic [31:0]       mem     [DEPTH_WORDS];
    rsp_t              pipe_q  [LATENCY];
    logic [LATENCY-1:0] pipe_v;
    rsp_t              fifo_q  [QDEPTH];
    logic [IDX_W-1:0]  rd_idx, wr_idx;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  inflight;

    logic [MEM_AW-1:0] rd_addr;
    logic [MEM_AW-1:0] ld_addr;
    rsp_t              read_entry;
    rsp_t              head;
    logic              head_valid;
    logic              fifo_empty;
    logic              accept;
    logic              transfer;
    logic              fifo_push;
    logic              fifo_pop;
    logic              unused_addr_bits;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_LAST) ? '0 : idx + 1'b1;
    endfunction

    // The word index keeps only the bits the memory needs, so out-of-range
    // indices wrap. The error check, when enabled, looks at the full address.
    assign rd_addr = req_addr[MEM_AW+1:2];
    assign ld_addr = load_addr[MEM_AW+1:2];
    assign unused_addr_bits = ^{req_addr, load_addr};

`ifdef IMEM_ERR_CHECK_EN
    logic read_err;

    // Combinational fetch with the alignment and range checks.
    always_comb begin
        read_err        = (req_addr[1:0] != 2'b00) || ((req_addr >> (MEM_AW + 2)) != '0);
        read_entry.err  = read_err;
        read_entry.data = read_err ? 32'h0 : mem[rd_addr];
    end
`else
    // Combinational fetch. Without the checks, the error flag is tied to 0.
    // NOTE: every signal assigned in always_comb gets a value on every path; otherwise a latch is inferred.
    always_comb begin
        read_entry.err  = 1'b0;
        read_entry.data = mem[rd_addr];
    end
`endif

    assign fifo_empty = (fifo_cnt == '0);
    assign head_valid = !fifo_empty || pipe_v[LATENCY-1];
    assign head       = fifo_empty ? pipe_q[LATENCY-1] : fifo_q[rd_idx];

    assign req_ready = !rst && !load_en && (inflight < QDEPTH_C);
    assign rsp_valid = !rst && head_valid;
    assign rsp_data  = rsp_valid ? head.data : 32'h0;
    assign rsp_err   = rsp_valid ? head.err : 1'b0;

    assign accept    = req_valid && req_ready;
    assign transfer  = rsp_valid && rsp_ready;
    // When the FIFO is empty and the consumer takes the response from the
    // last pipeline stage, the entry skips the FIFO.
    assign fifo_push = pipe_v[LATENCY-1] && !(fifo_empty && transfer);
    assign fifo_pop  = transfer && !fifo_empty;

    // Preload write port. Reset leaves the memory contents untouched.
    // NOTE: memory arrays carry no reset; resetting them would stop RAM inference and would erase the program.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[ld_addr] <= load_data;
        end
    end

    // Read pipeline: stage 0 captures the fetch result at acceptance.
    // NOTE: sequential state uses non-blocking assignment so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_v[0] <= accept;
            pipe_q[0] <= read_entry;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Response FIFO storage: entries that were not consumed straight from the pipeline.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_q[wr_idx] <= pipe_q[LATENCY-1];
        end
    end

    // FIFO pointers and occupancy. The pointers wrap modulo QDEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx   <= '0;
            wr_idx   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                wr_idx <= next_idx(wr_idx);
            end
            if (fifo_pop) begin
                rd_idx <= next_idx(rd_idx);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // In-flight count: requests that are accepted but not yet transferred.
    // Bounding it by QDEPTH keeps the FIFO from overflowing.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({accept, transfer})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed and random bench for imem_responder (default parameters: LATENCY 2, QDEPTH 4).
// Expectations for the address-error fetches follow IMEM_ERR_CHECK_EN.
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    int checks;
    int failures;

    logic [31:0] prog [4];
    logic [31:0] tb_mem [16];

    imem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int word, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = word * 4;
        load_data = data;
        #1;
        step();
        load_en = 1'b0;
    endtask

    // Wait up to 20 cycles for one response transfer; inputs are already set by the caller.
    task automatic wait_rsp(output logic [31:0] d, output logic e, output bit ok);
        ok = 1'b0;
        d  = 'x;
        e  = 'x;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rsp_valid && rsp_ready) begin
                d  = rsp_data;
                e  = rsp_err;
                ok = 1'b1;
                step();
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); step();
        #1;
        checks += 4;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        if (rsp_err !== 1'b0)   begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        rst = 1'b0;
        #1;
        checks += 2;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready got=%b exp=1", req_ready); end
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL post_reset_rsp_valid got=%b exp=0", rsp_valid); end
        step();
    endtask

    task automatic test_preload();
        for (int i = 0; i < 4; i++) do_load(i, prog[i]);
        do_load(4, 32'h1111_1111);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL preload_ready got=%b exp=1", req_ready); end
        step();
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            req_valid = (t < 4);
            req_addr  = (t < 4) ? t * 4 : 0;
            #1;
            if (t < 4) begin
                checks++;
                if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready t=%0d got=%b exp=1", t, req_ready); end
            end
            checks++;
            if (rsp_valid !== (t >= 2 && t <= 5)) begin
                failures++;
                $display("FAIL b2b_rsp_valid t=%0d got=%b exp=%b", t, rsp_valid, (t >= 2 && t <= 5));
            end
            if (t >= 2 && t <= 5) begin
                checks++;
                if (rsp_data !== prog[t-2]) begin
                    failures++;
                    $display("FAIL b2b_rsp_data t=%0d got=%h exp=%h", t, rsp_data, prog[t-2]);
                end
            end
            step();
        end
        req_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int          accepts;
        logic [31:0] d;
        logic        e;
        bit          ok;
        accepts   = 0;
        rsp_ready = 1'b0;
        for (int t = 0; t < 8; t++) begin
            req_valid = 1'b1;
            req_addr  = accepts * 4;
            #1;
            if (t >= 2) begin
                checks += 2;
                if (rsp_valid !== 1'b1)     begin failures++; $display("FAIL bp_hold_valid t=%0d got=%b exp=1", t, rsp_valid); end
                if (rsp_data !== prog[0])   begin failures++; $display("FAIL bp_hold_data t=%0d got=%h exp=%h", t, rsp_data, prog[0]); end
            end
            if (req_ready) accepts++;
            step();
        end
        #1;
        checks += 2;
        if (accepts != 4)       begin failures++; $display("FAIL bp_accepts got=%0d exp=4", accepts); end
        if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", req_ready); end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_rsp(d, e, ok);
            checks++;
            if (!ok || d !== prog[i]) begin
                failures++;
                $display("FAIL bp_drain_%0d got=%h ok=%0d exp=%h", i, d, ok, prog[i]);
            end
        end
    endtask

    task automatic test_addr_err();
        logic [31:0] d;
        logic        e;
        bit          ok;
        logic [31:0] exp_d;
        logic        exp_e;
`ifdef IMEM_ERR_CHECK_EN
        exp_d = 32'h0;
        exp_e = 1'b1;
`else
        exp_d = prog[0];
        exp_e = 1'b0;
`endif
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h2;
        step();
        req_addr  = 32'h400;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_rsp(d, e, ok);
            checks += 2;
            if (!ok || d !== exp_d) begin failures++; $display("FAIL err_data_%0d got=%h ok=%0d exp=%h", i, d, ok, exp_d); end
            if (!ok || e !== exp_e) begin failures++; $display("FAIL err_flag_%0d got=%b ok=%0d exp=%b", i, e, ok, exp_e); end
        end
    endtask

    task automatic test_load_bypass();
        logic [31:0] d;
        logic        e;
        bit          ok;
        rsp_ready = 1'b1;
        load_en   = 1'b1;
        load_addr = 32'h10;
        load_data = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL load_blocks_ready got=%b exp=0", req_ready); end
        step();
        load_en = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL load_next_ready got=%b exp=1", req_ready); end
        step();
        req_valid = 1'b0;
        wait_rsp(d, e, ok);
        checks++;
        if (!ok || d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_new_data got=%h ok=%0d exp=deadbeef", d, ok); end
    endtask

    task automatic test_reset_flush();
        logic [31:0] d;
        logic        e;
        bit          ok;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = i * 4;
            step();
        end
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks += 2;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL flush_valid_in_rst got=%b exp=0", rsp_valid); end
        if (req_ready !== 1'b0) begin failures++; $display("FAIL flush_ready_in_rst got=%b exp=0", req_ready); end
        step();
        rst = 1'b0;
        #1;
        checks += 2;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL flush_ready_after got=%b exp=1", req_ready); end
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL flush_valid_after got=%b exp=0", rsp_valid); end
        step();
        rsp_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin failures++; $display("FAIL flush_stale t=%0d got=%b exp=0 data=%h", t, rsp_valid, rsp_data); end
            step();
        end
        // The memory survives reset.
        req_valid = 1'b1;
        req_addr  = 32'h0;
        step();
        req_valid = 1'b0;
        wait_rsp(d, e, ok);
        checks++;
        if (!ok || d !== prog[0]) begin failures++; $display("FAIL mem_after_reset got=%h ok=%0d exp=%h", d, ok, prog[0]); end
    endtask

    task automatic test_stress();
        logic [31:0] expq [$];
        int          sent;
        int          outstanding;
        int          word;
        int          cycles;
        logic [31:0] exp_d;
        for (int i = 0; i < 16; i++) begin
            tb_mem[i] = $urandom;
            do_load(i, tb_mem[i]);
        end
        sent        = 0;
        outstanding = 0;
        cycles      = 0;
        while ((sent < 10000 || outstanding > 0) && cycles < 60000) begin
            word      = $urandom_range(0, 15);
            req_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
            req_addr  = word * 4;
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (req_ready !== (outstanding < 4)) begin
                failures++;
                $display("FAIL stress_ready cyc=%0d got=%b exp=%b inflight=%0d", cycles, req_ready, (outstanding < 4), outstanding);
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL stress_extra cyc=%0d got=%h exp=none", cycles, rsp_data);
                end else begin
                    exp_d = expq.pop_front();
                    if (rsp_data !== exp_d || rsp_err !== 1'b0) begin
                        failures++;
                        $display("FAIL stress_data cyc=%0d got=%h err=%b exp=%h err=0", cycles, rsp_data, rsp_err, exp_d);
                    end
                end
                outstanding--;
            end
            if (req_valid && req_ready) begin
                expq.push_back(tb_mem[word]);
                sent++;
                outstanding++;
            end
            step();
            cycles++;
        end
        req_valid = 1'b0;
        checks += 2;
        if (sent != 10000)    begin failures++; $display("FAIL stress_sent got=%0d exp=10000", sent); end
        if (outstanding != 0) begin failures++; $display("FAIL stress_drained got=%0d exp=0", outstanding); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        prog[0]   = 32'h0000_0013;
        prog[1]   = 32'h0010_0093;
        prog[2]   = 32'h0020_0113;
        prog[3]   = 32'h0030_0193;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        test_reset();
        test_preload();
        test_back_to_back();
        test_backpressure();
        test_addr_err();
        test_load_bypass();
        test_reset_flush();
        test_stress();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
